// File: rtl/collision_detect.sv
// -----------------------------------------------------------------------------
// collision_detect
//
// Purpose:
//   Watches the live pixel stream and compares the obstacle colour index from
//   the level block with the player sprite colour index. It counts the pixels
//   inside the playfield window where both are opaque. A frame "qualifies" when
//   its count reaches MIN_OVERLAP. After CONFIRM_FRAMES consecutive qualifying
//   frames the block confirms a collision. It then emits a one-cycle hit pulse,
//   latches fail, and freezes the position of the first overlap pixel of the
//   confirming frame.
//
// Ports:
//   CLK, RESET     system clock, synchronous active-high reset
//   pix_stb        one-cycle pixel strobe; qualifies hc/vc/pixel inputs
//   state          game state from the top-level FSM (running = 5..10)
//   hc, vc         VGA horizontal / vertical counters
//   obstacle_pix   obstacle colour index, 0 = transparent
//   duck_pix       player colour index, 0 = transparent
//   hit            one-cycle pulse on confirmed collision
//   fail           latched collision flag
//   hit_x, hit_y   first overlap position in the confirming frame
//   overlap_cnt    overlap count of the last completed frame (saturating)
//   hilite_pix     debug overlay pixel
//
// Build option:
//   COLLISION_HILITE_EN - when defined, hilite_pix is a registered 4'hF one
//   cycle after every overlap pixel. When undefined, hilite_pix is 4'h0.
// -----------------------------------------------------------------------------
module collision_detect #(
    parameter int H_MIN          = 170,
    parameter int H_MAX          = 750,
    parameter int HC_END         = 799,
    parameter int VC_END         = 524,
    parameter int MIN_OVERLAP    = 4,
    parameter int CONFIRM_FRAMES = 2,
    parameter int CNT_W          = 12
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pix_stb,
    input  logic [3:0]       state,
    input  logic [9:0]       hc,
    input  logic [9:0]       vc,
    input  logic [3:0]       obstacle_pix,
    input  logic [3:0]       duck_pix,
    output logic             hit,
    output logic             fail,
    output logic [9:0]       hit_x,
    output logic [9:0]       hit_y,
    output logic [CNT_W-1:0] overlap_cnt,
    output logic [3:0]       hilite_pix
);

    localparam int STREAK_W = $clog2(CONFIRM_FRAMES + 1);

    localparam logic [9:0]          H_MIN_C     = 10'(H_MIN);
    localparam logic [9:0]          H_MAX_C     = 10'(H_MAX);
    localparam logic [9:0]          HC_END_C    = 10'(HC_END);
    localparam logic [9:0]          VC_END_C    = 10'(VC_END);
    localparam logic [CNT_W-1:0]    MIN_OV_C    = CNT_W'(MIN_OVERLAP);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [STREAK_W-1:0] CONFIRM_C   = STREAK_W'(CONFIRM_FRAMES);
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);

    localparam logic [3:0] ST_TITLE_MAX = 4'd4;
    localparam logic [3:0] ST_RUN1      = 4'd5;
    localparam logic [3:0] ST_DUCK2     = 4'd10;
    localparam logic [3:0] ST_IDLE      = 4'd11;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        SCAN  = 2'd1,
        HIT   = 2'd2
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    overlap_cnt_q, overlap_cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                first_q, first_d;
    logic [9:0]          cand_x_q, cand_x_d;
    logic [9:0]          cand_y_q, cand_y_d;
    logic [9:0]          hit_x_q, hit_x_d;
    logic [9:0]          hit_y_q, hit_y_d;
    logic                hit_q, hit_d;
    logic                fail_q, fail_d;

    logic                running_s;
    logic                overlap_s;
    logic                frame_end_s;
    logic                exit_hit_s;
    logic [CNT_W-1:0]    count_inc_s;
    logic [STREAK_W-1:0] streak_inc_s;
    logic [9:0]          cand_x_now_s;
    logic [9:0]          cand_y_now_s;
    logic                qualify_s;

    // Pixel qualification and the frame's count including the current pixel
    always_comb begin
        running_s   = (state >= ST_RUN1) && (state <= ST_DUCK2);
        overlap_s   = pix_stb && running_s && (hc >= H_MIN_C) && (hc <= H_MAX_C)
                      && (obstacle_pix != 4'd0) && (duck_pix != 4'd0);
        frame_end_s = pix_stb && (hc == HC_END_C) && (vc == VC_END_C);
        exit_hit_s  = (state == ST_IDLE) || (state <= ST_TITLE_MAX);
        // The frame_end pixel itself still belongs to the ending frame, so it
        // is folded in before the qualify test.
        if (overlap_s && (count_q != CNT_MAX)) begin
            count_inc_s = count_q + CNT_ONE;
        end else begin
            count_inc_s = count_q;
        end
        if (overlap_s && !first_q) begin
            cand_x_now_s = hc;
            cand_y_now_s = vc;
        end else begin
            cand_x_now_s = cand_x_q;
            cand_y_now_s = cand_y_q;
        end
        streak_inc_s = streak_q + STREAK_ONE;
        qualify_s    = (count_inc_s >= MIN_OV_C);
    end

    // Next-state logic for the ARMED / SCAN / HIT controller and its datapath
    always_comb begin
        fsm_d         = fsm_q;
        count_d       = count_q;
        overlap_cnt_d = overlap_cnt_q;
        streak_d      = streak_q;
        first_d       = first_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        hit_x_d       = hit_x_q;
        hit_y_d       = hit_y_q;
        hit_d         = 1'b0;
        fail_d        = fail_q;
        case (fsm_q)
            ARMED: begin
                if (running_s) begin
                    fsm_d = SCAN;
                end else begin
                    fsm_d = ARMED;
                end
            end
            SCAN: begin
                if (!running_s) begin
                    // Leaving play abandons the partial frame and the streak.
                    fsm_d    = ARMED;
                    count_d  = {CNT_W{1'b0}};
                    streak_d = {STREAK_W{1'b0}};
                    first_d  = 1'b0;
                    cand_x_d = 10'd0;
                    cand_y_d = 10'd0;
                end else if (frame_end_s) begin
                    overlap_cnt_d = count_inc_s;
                    count_d       = {CNT_W{1'b0}};
                    first_d       = 1'b0;
                    cand_x_d      = 10'd0;
                    cand_y_d      = 10'd0;
                    if (qualify_s) begin
                        streak_d = streak_inc_s;
                        if (streak_inc_s == CONFIRM_C) begin
                            fsm_d   = HIT;
                            hit_d   = 1'b1;
                            fail_d  = 1'b1;
                            hit_x_d = cand_x_now_s;
                            hit_y_d = cand_y_now_s;
                        end else begin
                            fsm_d = SCAN;
                        end
                    end else begin
                        streak_d = {STREAK_W{1'b0}};
                    end
                end else begin
                    count_d  = count_inc_s;
                    cand_x_d = cand_x_now_s;
                    cand_y_d = cand_y_now_s;
                    first_d  = first_q | overlap_s;
                end
            end
            HIT: begin
                // FAIL1/FAIL2 keep the latch; only IDLE or TITLE re-arm.
                if (exit_hit_s) begin
                    fsm_d    = ARMED;
                    fail_d   = 1'b0;
                    streak_d = {STREAK_W{1'b0}};
                end else begin
                    fsm_d  = HIT;
                    fail_d = 1'b1;
                end
            end
            default: begin
                fsm_d = ARMED;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm_q         <= ARMED;
            count_q       <= {CNT_W{1'b0}};
            overlap_cnt_q <= {CNT_W{1'b0}};
            streak_q      <= {STREAK_W{1'b0}};
            first_q       <= 1'b0;
            cand_x_q      <= 10'd0;
            cand_y_q      <= 10'd0;
            hit_x_q       <= 10'd0;
            hit_y_q       <= 10'd0;
            hit_q         <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            count_q       <= count_d;
            overlap_cnt_q <= overlap_cnt_d;
            streak_q      <= streak_d;
            first_q       <= first_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            hit_x_q       <= hit_x_d;
            hit_y_q       <= hit_y_d;
            hit_q         <= hit_d;
            fail_q        <= fail_d;
        end
    end

    assign hit         = hit_q;
    assign fail        = fail_q;
    assign hit_x       = hit_x_q;
    assign hit_y       = hit_y_q;
    assign overlap_cnt = overlap_cnt_q;

`ifdef COLLISION_HILITE_EN
    logic [3:0] hilite_pix_q, hilite_pix_d;

    // Overlay colour follows each overlap pixel by one cycle
    always_comb begin
        if (overlap_s) begin
            hilite_pix_d = 4'hF;
        end else begin
            hilite_pix_d = 4'h0;
        end
    end

    // Overlay register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hilite_pix_q <= 4'h0;
        end else begin
            hilite_pix_q <= hilite_pix_d;
        end
    end

    assign hilite_pix = hilite_pix_q;
`else
    assign hilite_pix = 4'b0000;
`endif

endmodule

// File: tb/tb_collision_detect.sv
// -----------------------------------------------------------------------------
// tb_collision_detect
//
// Drives compressed frames: only the interesting pixels are presented, and then
// the frame-end pixel (799,524). Expected per-frame results are queued when the
// frame-end pixel is driven. They are popped and compared in the cycle after
// the DUT samples that pixel.
// -----------------------------------------------------------------------------
module tb_collision_detect;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        pix_stb;
    logic [3:0]  state;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [3:0]  obstacle_pix;
    logic [3:0]  duck_pix;
    logic        hit;
    logic        fail;
    logic [9:0]  hit_x;
    logic [9:0]  hit_y;
    logic [11:0] overlap_cnt;
    logic [3:0]  hilite_pix;

    collision_detect dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .pix_stb      (pix_stb),
        .state        (state),
        .hc           (hc),
        .vc           (vc),
        .obstacle_pix (obstacle_pix),
        .duck_pix     (duck_pix),
        .hit          (hit),
        .fail         (fail),
        .hit_x        (hit_x),
        .hit_y        (hit_y),
        .overlap_cnt  (overlap_cnt),
        .hilite_pix   (hilite_pix)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] cnt;
        logic        hit;
        logic        fail;
        logic [9:0]  x;
        logic [9:0]  y;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic started = 1'b0;
    logic fe_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Remember whether the DUT just sampled a frame-end pixel
    always @(posedge CLK) begin
        fe_seen <= pix_stb && (hc == 10'd799) && (vc == 10'd524) && !RESET;
    end

    // Scoreboard: compare frame results; otherwise hit must stay low
    always @(negedge CLK) begin
        if (started) begin
            if (fe_seen) begin
                check_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check_eq("overlap_cnt", 32'(overlap_cnt), 32'(mon_e.cnt));
                    check_eq("hit_pulse", 32'(hit), 32'(mon_e.hit));
                    check_eq("fail", 32'(fail), 32'(mon_e.fail));
                    check_eq("hit_x", 32'(hit_x), 32'(mon_e.x));
                    check_eq("hit_y", 32'(hit_y), 32'(mon_e.y));
                end
            end else begin
                check_eq("hit_idle", 32'(hit), 32'd0);
            end
        end
    end

    task automatic step(input logic stb, input logic [9:0] h, input logic [9:0] v,
                        input logic [3:0] o, input logic [3:0] d);
        pix_stb      = stb;
        hc           = h;
        vc           = v;
        obstacle_pix = o;
        duck_pix     = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic end_frame(input logic [11:0] c, input logic h, input logic f,
                             input logic [9:0] x, input logic [9:0] y);
        exp_t e;
        e.cnt = c;
        e.hit = h;
        e.fail = f;
        e.x = x;
        e.y = y;
        sb_q.push_back(e);
        step(1'b1, 10'd799, 10'd524, 4'h0, 4'h0);
        step(1'b0, 10'd0, 10'd0, 4'h7, 4'h7);
    endtask

    // n overlap pixels from (x0,y), with a strobe gap and two half-transparent pixels
    task automatic run_frame(input logic [9:0] x0, input logic [9:0] y, input int n,
                             input logic [11:0] c, input logic h, input logic f,
                             input logic [9:0] ex, input logic [9:0] ey);
        step(1'b0, x0, y, 4'h7, 4'h7);
        step(1'b0, x0, y, 4'h7, 4'h7);
        for (int i = 0; i < n; i++) begin
            step(1'b1, x0 + 10'(i), y, 4'h7, 4'h7);
            if (i == 1) step(1'b0, x0, y, 4'h7, 4'h7);
        end
        step(1'b1, x0 + 10'(n), y, 4'h0, 4'h7);
        step(1'b1, x0 + 10'(n + 1), y, 4'h7, 4'h0);
        end_frame(c, h, f, ex, ey);
    endtask

    initial begin
        // Reset while pixels are flowing
        RESET = 1'b1;
        state = 4'd5;
        step(1'b1, 10'd300, 10'd280, 4'h7, 4'h7);
        step(1'b1, 10'd301, 10'd280, 4'h7, 4'h7);
        RESET = 1'b0;
        check_eq("rst_hit", 32'(hit), 32'd0);
        check_eq("rst_fail", 32'(fail), 32'd0);
        check_eq("rst_hit_x", 32'(hit_x), 32'd0);
        check_eq("rst_hit_y", 32'(hit_y), 32'd0);
        check_eq("rst_cnt", 32'(overlap_cnt), 32'd0);
        started = 1'b1;

        // Two qualifying frames confirm a hit
        run_frame(10'd300, 10'd280, 6, 12'd6, 1'b0, 1'b0, 10'd0, 10'd0);
        run_frame(10'd300, 10'd280, 6, 12'd6, 1'b1, 1'b1, 10'd300, 10'd280);
        // Latched: overlaps ignored, position frozen
        run_frame(10'd320, 10'd290, 6, 12'd6, 1'b0, 1'b1, 10'd300, 10'd280);

        // Mid-frame reset clears everything, following partial frame counts
        step(1'b1, 10'd500, 10'd300, 4'h7, 4'h7);
        RESET = 1'b1;
        step(1'b1, 10'd501, 10'd300, 4'h7, 4'h7);
        step(1'b1, 10'd502, 10'd300, 4'h7, 4'h7);
        RESET = 1'b0;
        check_eq("rst2_fail", 32'(fail), 32'd0);
        check_eq("rst2_hit_x", 32'(hit_x), 32'd0);
        check_eq("rst2_hit_y", 32'(hit_y), 32'd0);
        check_eq("rst2_cnt", 32'(overlap_cnt), 32'd0);
        run_frame(10'd500, 10'd300, 5, 12'd5, 1'b0, 1'b0, 10'd0, 10'd0);

        // Below MIN_OVERLAP for five frames: never a hit
        for (int k = 0; k < 5; k++) begin
            run_frame(10'd600, 10'd310, 3, 12'd3, 1'b0, 1'b0, 10'd0, 10'd0);
        end

        // Leaving play mid-frame discards the partial count (2 + 3 -> 3)
        step(1'b1, 10'd400, 10'd20, 4'h7, 4'h7);
        step(1'b1, 10'd401, 10'd20, 4'h7, 4'h7);
        state = 4'd12;
        step(1'b0, 10'd402, 10'd20, 4'h7, 4'h7);
        state = 4'd5;
        run_frame(10'd410, 10'd21, 3, 12'd3, 1'b0, 1'b0, 10'd0, 10'd0);

        // Streak broken by an empty frame, then two consecutive frames confirm
        run_frame(10'd200, 10'd100, 4, 12'd4, 1'b0, 1'b0, 10'd0, 10'd0);
        run_frame(10'd200, 10'd100, 0, 12'd0, 1'b0, 1'b0, 10'd0, 10'd0);
        run_frame(10'd210, 10'd100, 4, 12'd4, 1'b0, 1'b0, 10'd0, 10'd0);
        run_frame(10'd220, 10'd101, 4, 12'd4, 1'b1, 1'b1, 10'd220, 10'd101);

        // FAIL1/FAIL2 hold the latch, IDLE releases it
        state = 4'd14;
        step(1'b0, 10'd0, 10'd0, 4'h7, 4'h7);
        check_eq("fail1_hold", 32'(fail), 32'd1);
        state = 4'd15;
        step(1'b0, 10'd0, 10'd0, 4'h7, 4'h7);
        check_eq("fail2_hold", 32'(fail), 32'd1);
        check_eq("fail2_hit_x", 32'(hit_x), 32'd220);
        state = 4'd11;
        step(1'b0, 10'd0, 10'd0, 4'h7, 4'h7);
        check_eq("idle_release", 32'(fail), 32'd0);

        // Window edges: just outside never counts, the bounds do
        state = 4'd6;
        step(1'b0, 10'd0, 10'd0, 4'h7, 4'h7);
        step(1'b1, 10'd160, 10'd200, 4'h7, 4'h7);
        step(1'b1, 10'd169, 10'd200, 4'h7, 4'h7);
        step(1'b1, 10'd751, 10'd200, 4'h7, 4'h7);
        step(1'b1, 10'd760, 10'd200, 4'h7, 4'h7);
        end_frame(12'd0, 1'b0, 1'b0, 10'd220, 10'd101);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 10'd170, 10'd200, 4'h7, 4'h7);
            step(1'b1, 10'd171, 10'd200, 4'h3, 4'h9);
            step(1'b1, 10'd749, 10'd200, 4'h7, 4'h7);
            step(1'b1, 10'd750, 10'd200, 4'h7, 4'h7);
            if (k == 0) end_frame(12'd4, 1'b0, 1'b0, 10'd220, 10'd101);
            else        end_frame(12'd4, 1'b1, 1'b1, 10'd170, 10'd200);
        end
        state = 4'd2;
        step(1'b0, 10'd0, 10'd0, 4'h7, 4'h7);
        check_eq("title_release", 32'(fail), 32'd0);

        // Counter saturation
        state = 4'd9;
        step(1'b0, 10'd0, 10'd0, 4'h0, 4'h0);
        for (int i = 0; i < 4100; i++) begin
            step(1'b1, 10'(170 + (i % 500)), 10'(i / 500), 4'h7, 4'h7);
        end
        end_frame(12'd4095, 1'b0, 1'b0, 10'd170, 10'd200);

        // Highlight overlay
        step(1'b1, 10'd400, 10'd50, 4'h7, 4'h7);
`ifdef COLLISION_HILITE_EN
        check_eq("hilite_on", 32'(hilite_pix), 32'hF);
`else
        check_eq("hilite_on", 32'(hilite_pix), 32'h0);
`endif
        step(1'b1, 10'd401, 10'd50, 4'h0, 4'h7);
        check_eq("hilite_off", 32'(hilite_pix), 32'h0);
        state = 4'd11;
        step(1'b1, 10'd402, 10'd50, 4'h7, 4'h7);
        check_eq("hilite_idle", 32'(hilite_pix), 32'h0);

        step(1'b0, 10'd0, 10'd0, 4'h0, 4'h0);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
